// File: rtl/hub75e_sched_pkg.sv
// hub75e_sched_pkg: shared engine states and timing constants for the HUB75E scan scheduler
// HUB75E_GHOST_GUARD_EN: lengthens blanking to 4 clocks and moves the address update into it.
package hub75e_sched_pkg;
  typedef enum logic [1:0] {SH_IDLE, SH_RUN, SH_DONE} sh_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_BLANK, OUT_LATCH, OUT_ON} out_state_e;
  localparam int PHASES_PER_COL = 4;
  localparam int LATCH_CYCLES = 2;
`ifdef HUB75E_GHOST_GUARD_EN
  localparam int BLANK_CYCLES = 4;
  localparam int ADDR_BLANK_CNT = 1;
`else
  localparam int BLANK_CYCLES = 1;
  localparam int ADDR_BLANK_CNT = 0;
`endif
endpackage

// File: rtl/hub75e_column_shifter.sv
// hub75e_column_shifter: serialises one line (upper and lower half) of one bit-plane, 4 clocks per column
// Ports: start/row_in/plane_in launch a line; x/y fetch pixels; r1..b2/ck shift them out;
// done is high from the last shift clock on; idle until the first start; row/plane are the latched line.
module hub75e_column_shifter
  import hub75e_sched_pkg::*;
#(
  parameter int screen_width = 64,
  parameter int screen_height = 64,
  parameter int w_color = 1,
  parameter int w_x = $clog2(screen_width),
  parameter int w_y = $clog2(screen_height),
  parameter int w_r = w_y - 1,
  parameter int w_p = (w_color > 1) ? $clog2(w_color) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [w_r-1:0]     row_in,
  input  logic [w_p-1:0]     plane_in,
  input  logic [w_color-1:0] red,
  input  logic [w_color-1:0] green,
  input  logic [w_color-1:0] blue,
  output logic [w_x-1:0]     x,
  output logic [w_y-1:0]     y,
  output logic               r1,
  output logic               g1,
  output logic               b1,
  output logic               r2,
  output logic               g2,
  output logic               b2,
  output logic               ck,
  output logic               done,
  output logic               idle,
  output logic [w_r-1:0]     row,
  output logic [w_p-1:0]     plane
);
  localparam int W_C = $clog2(screen_width * PHASES_PER_COL);
  localparam int LAST = screen_width * PHASES_PER_COL - 1;
  localparam int ROWS = screen_height / 2;
  sh_state_e state_q, state_d;
  logic [W_C-1:0] cnt_q, cnt_d;
  logic [w_r-1:0] row_q, row_d;
  logic [w_p-1:0] plane_q, plane_d;
  logic [w_x-1:0] x_q, x_d;
  logic [w_y-1:0] y_q, y_d;
  logic [2:0] top_q, top_d, pix;
  logic [5:0] dat_q, dat_d;
  logic ck_q, ck_d, run_d;
  logic [1:0] ph_d;
  logic [w_color-1:0] sel;
  // outputs are registered from the next phase so x/y appear in the phase they belong to
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    row_d = row_q;
    plane_d = plane_q;
    if (state_q == SH_RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == W_C'(LAST)) state_d = SH_DONE;
    end else if (start) begin
      state_d = SH_RUN;
      cnt_d = '0;
      row_d = row_in;
      plane_d = plane_in;
    end
    run_d = state_d == SH_RUN;
    ph_d = cnt_d[1:0];
    sel = w_color'(1) << plane_q;
    pix = {|(red & sel), |(green & sel), |(blue & sel)};
    x_d = (run_d && ph_d == 2'd0) ? cnt_d[W_C-1:2] : x_q;
    y_d = !run_d ? y_q : (ph_d == 2'd0) ? w_y'(row_d) : (ph_d == 2'd1) ? w_y'(row_d) + w_y'(ROWS) : y_q;
    top_d = (run_d && ph_d == 2'd1) ? pix : top_q;
    dat_d = (run_d && ph_d == 2'd2) ? {top_q, pix} : dat_q;
    ck_d = run_d && ph_d == 2'd3;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SH_IDLE;
      cnt_q <= '0;
      row_q <= '0;
      plane_q <= '0;
      x_q <= '0;
      y_q <= '0;
      top_q <= '0;
      dat_q <= '0;
      ck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      plane_q <= plane_d;
      x_q <= x_d;
      y_q <= y_d;
      top_q <= top_d;
      dat_q <= dat_d;
      ck_q <= ck_d;
    end
  end
  // done already on the last shift clock so blanking can start on the same edge the line ends
  assign done = (state_q == SH_RUN && cnt_q == W_C'(LAST)) || state_q == SH_DONE;
  assign idle = state_q == SH_IDLE;
  assign x = x_q;
  assign y = y_q;
  assign {r1, g1, b1, r2, g2, b2} = dat_q;
  assign ck = ck_q;
  assign row = row_q;
  assign plane = plane_q;
endmodule

// File: rtl/hub75e_scan_scheduler.sv
// hub75e_scan_scheduler: HUB75E 1/32-scan panel sequencer with BCM planes and overlapped line shifting
// Ports: x/y request pixels, red/green/blue answer combinationally; r1..b2/ck shift data;
// a..e row address, st latch, oe active-low enable, frame_start pulses on row 0 plane 0 display.
// HUB75E_GHOST_GUARD_EN: 4-clock blanking with the address updated mid-blank.
module hub75e_scan_scheduler
  import hub75e_sched_pkg::*;
#(
  parameter int screen_width = 64,
  parameter int screen_height = 64,
  parameter int w_color = 1,
  parameter int base_on_cycles = 256,
  parameter int w_x = $clog2(screen_width),
  parameter int w_y = $clog2(screen_height)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [w_x-1:0]     x,
  output logic [w_y-1:0]     y,
  input  logic [w_color-1:0] red,
  input  logic [w_color-1:0] green,
  input  logic [w_color-1:0] blue,
  output logic               r1,
  output logic               g1,
  output logic               b1,
  output logic               r2,
  output logic               g2,
  output logic               b2,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               e,
  output logic               ck,
  output logic               st,
  output logic               oe,
  output logic               frame_start
);
  localparam int W_R = w_y - 1;
  localparam int W_P = (w_color > 1) ? $clog2(w_color) : 1;
  localparam int ROWS = screen_height / 2;
  localparam int TW = $clog2((base_on_cycles << (w_color - 1)) + 1);
  out_state_e out_q, out_d;
  logic [1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0] addr_q, addr_d;
  logic [W_P-1:0] dplane_q, dplane_d, pplane_q, pplane_d, sh_plane;
  logic [W_R-1:0] prow_q, prow_d, sh_row;
  logic st_q, st_d, oe_q, oe_d, fs_q, fs_d, start, sh_done, sh_idle;
  // prow/pplane point at the next line to shift; addr/dplane describe the line being displayed
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q + 1'b1;
    tmr_d = (tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
    addr_d = addr_q;
    dplane_d = dplane_q;
    start = 1'b0;
    fs_d = 1'b0;
    if (out_q == OUT_IDLE) begin
      start = sh_idle;
      cnt_d = '0;
      if (sh_done) out_d = OUT_BLANK;
    end else if (out_q == OUT_BLANK) begin
      if (cnt_q == 2'(ADDR_BLANK_CNT)) begin
        addr_d = 5'(sh_row);
        dplane_d = sh_plane;
      end
      if (cnt_q == 2'(BLANK_CYCLES - 1)) begin
        out_d = OUT_LATCH;
        cnt_d = '0;
      end
    end else if (out_q == OUT_LATCH) begin
      if (cnt_q == 2'(LATCH_CYCLES - 1)) begin
        out_d = OUT_ON;
        start = 1'b1;
        tmr_d = TW'(base_on_cycles) << dplane_q;
        fs_d = (addr_q == '0) && (dplane_q == '0);
      end
    end else if (tmr_q <= TW'(1) && sh_done) begin
      out_d = OUT_BLANK;
      cnt_d = '0;
    end
    prow_d = prow_q;
    pplane_d = pplane_q;
    if (start) begin
      pplane_d = (pplane_q == W_P'(w_color - 1)) ? '0 : pplane_q + 1'b1;
      prow_d = (pplane_q != W_P'(w_color - 1)) ? prow_q : (prow_q == W_R'(ROWS - 1)) ? '0 : prow_q + 1'b1;
    end
    st_d = out_d == OUT_LATCH;
    oe_d = !(out_d == OUT_ON && tmr_d != '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= OUT_IDLE;
      cnt_q <= '0;
      tmr_q <= '0;
      addr_q <= '0;
      dplane_q <= '0;
      pplane_q <= '0;
      prow_q <= '0;
      st_q <= 1'b0;
      oe_q <= 1'b1;
      fs_q <= 1'b0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      addr_q <= addr_d;
      dplane_q <= dplane_d;
      pplane_q <= pplane_d;
      prow_q <= prow_d;
      st_q <= st_d;
      oe_q <= oe_d;
      fs_q <= fs_d;
    end
  end
  hub75e_column_shifter #(
    .screen_width(screen_width),
    .screen_height(screen_height),
    .w_color(w_color),
    .w_x(w_x),
    .w_y(w_y),
    .w_r(W_R),
    .w_p(W_P)
  ) u_shift (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .row_in(prow_q),
    .plane_in(pplane_q),
    .red(red),
    .green(green),
    .blue(blue),
    .x(x),
    .y(y),
    .r1(r1),
    .g1(g1),
    .b1(b1),
    .r2(r2),
    .g2(g2),
    .b2(b2),
    .ck(ck),
    .done(sh_done),
    .idle(sh_idle),
    .row(sh_row),
    .plane(sh_plane)
  );
  assign {e, d, c, b, a} = addr_q;
  assign st = st_q;
  assign oe = oe_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_hub75e_scan_scheduler.sv
// tb_hub75e_scan_scheduler: checks a 1-plane and a 2-plane scheduler cycle by cycle against a line-schedule model
module tb_hub75e_scan_scheduler;
`ifdef HUB75E_GHOST_GUARD_EN
  localparam int BL = 4, GA = 2;
`else
  localparam int BL = 1, GA = 0;
`endif
  localparam int NL = 64, SHIFT = 256, BASE = 256;
  typedef struct packed {
    logic oe, st, fs, ck;
    logic [4:0] addr;
    int line, col, ph;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] img_r [64][64];
  logic [1:0] img_g [64][64];
  logic [1:0] img_b [64][64];
  int t1 [NL];
  int s1 [NL];
  int t2 [NL];
  int s2 [NL];
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [5:0] x1, y1, x2, y2, dat1, dat2;
  logic [4:0] ad1, ad2;
  logic red1, green1, blue1, ck1, st1, oe1, fs1, ck2, st2, oe2, fs2;
  logic [1:0] red2, green2, blue2;
  assign red1 = img_r[y1][x1][0];
  assign green1 = img_g[y1][x1][0];
  assign blue1 = img_b[y1][x1][0];
  assign red2 = img_r[y2][x2];
  assign green2 = img_g[y2][x2];
  assign blue2 = img_b[y2][x2];
  hub75e_scan_scheduler u_dut1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1),
    .red(red1), .green(green1), .blue(blue1),
    .r1(dat1[5]), .g1(dat1[4]), .b1(dat1[3]), .r2(dat1[2]), .g2(dat1[1]), .b2(dat1[0]),
    .a(ad1[0]), .b(ad1[1]), .c(ad1[2]), .d(ad1[3]), .e(ad1[4]),
    .ck(ck1), .st(st1), .oe(oe1), .frame_start(fs1)
  );
  hub75e_scan_scheduler #(.w_color(2), .base_on_cycles(BASE)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .x(x2), .y(y2),
    .red(red2), .green(green2), .blue(blue2),
    .r1(dat2[5]), .g1(dat2[4]), .b1(dat2[3]), .r2(dat2[2]), .g2(dat2[1]), .b2(dat2[0]),
    .a(ad2[0]), .b(ad2[1]), .c(ad2[2]), .d(ad2[3]), .e(ad2[4]),
    .ck(ck2), .st(st2), .oe(oe2), .frame_start(fs2)
  );
  task automatic chk(input bit sel, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL dut%0d %s at cycle %0d: observed %0h expected %0h", sel + 1, tag, cyc, obs, exp);
    end
  endtask
  function automatic logic [2:0] pix(input int r, input int c, input int pl);
    return {img_r[r][c][pl], img_g[r][c][pl], img_b[r][c][pl]};
  endfunction
  // Line l is shifted from edge t[l]; its display starts at s[l] once both its shift and the previous display are over.
  function automatic exp_t model(input bit sel, input int n);
    exp_t m;
    int wc, t, s, on;
    wc = sel ? 2 : 1;
    m = '0;
    m.oe = 1'b1;
    m.line = -1;
    for (int l = 0; l < NL; l++) begin
      t = sel ? t2[l] : t1[l];
      s = sel ? s2[l] : s1[l];
      if (t > n) break;
      on = BASE << (l % wc);
      if (n >= s && n < s + on) m.oe = 1'b0;
      if (n >= s - 2 && n < s) m.st = 1'b1;
      if (n >= s - 2 - GA) m.addr = 5'((l / wc) % 32);
      if (n == s && l % (32 * wc) == 0) m.fs = 1'b1;
      if (n < t + SHIFT) begin
        m.line = l;
        m.col = (n - t) / 4;
        m.ph = (n - t) % 4;
        m.ck = m.ph == 3;
      end
    end
    return m;
  endfunction
  task automatic check_dut(input bit sel, input logic oe, input logic st, input logic fs, input logic ck,
                           input logic [4:0] addr, input logic [5:0] dat, input logic [5:0] xx, input logic [5:0] yy);
    exp_t m;
    int wc, row, pl;
    m = model(sel, cyc);
    wc = sel ? 2 : 1;
    chk(sel, "oe", oe, m.oe);
    chk(sel, "st", st, m.st);
    chk(sel, "addr", addr, m.addr);
    chk(sel, "frame_start", fs, m.fs);
    chk(sel, "ck", ck, m.ck);
    if (m.line >= 0) begin
      row = (m.line / wc) % 32;
      pl = m.line % wc;
      if (m.ph == 3) chk(sel, "data", dat, {pix(row, m.col, pl), pix(row + 32, m.col, pl)});
      if (m.ph == 0) chk(sel, "xy_top", {xx, yy}, {6'(m.col), 6'(row)});
      if (m.ph == 1) chk(sel, "xy_bottom", {xx, yy}, {6'(m.col), 6'(row + 32)});
    end
  endtask
  task automatic check_reset(input bit sel, input logic oe, input logic st, input logic fs, input logic ck,
                             input logic [4:0] addr, input logic [5:0] dat, input logic [5:0] xx, input logic [5:0] yy);
    chk(sel, "rst_oe", oe, 1);
    chk(sel, "rst_st", st, 0);
    chk(sel, "rst_fs", fs, 0);
    chk(sel, "rst_ck", ck, 0);
    chk(sel, "rst_addr", addr, 0);
    chk(sel, "rst_data", dat, 0);
    chk(sel, "rst_xy", {xx, yy}, 0);
  endtask
  task automatic fill_image(input bit rnd);
    for (int yy = 0; yy < 64; yy++)
      for (int xx = 0; xx < 64; xx++) begin
        img_r[yy][xx] = rnd ? 2'($urandom) : ((yy >= 32) ? 2'b11 : 2'b00);
        img_g[yy][xx] = 2'($urandom);
        img_b[yy][xx] = 2'($urandom);
      end
  endtask
  task automatic run(input int cycles);
    for (int n = 1; n <= cycles; n++) begin
      @(posedge clk);
      @(negedge clk);
      cyc = n;
      check_dut(0, oe1, st1, fs1, ck1, ad1, dat1, x1, y1);
      check_dut(1, oe2, st2, fs2, ck2, ad2, dat2, x2, y2);
    end
  endtask
  initial begin
    for (int l = 0; l < NL; l++) begin
      t1[l] = (l == 0) ? 1 : s1[l-1];
      t2[l] = (l == 0) ? 1 : s2[l-1];
      s1[l] = ((l == 0) ? t1[l] + SHIFT : s1[l-1] + ((BASE > SHIFT) ? BASE : SHIFT)) + BL + 2;
      s2[l] = ((l == 0) ? t2[l] + SHIFT : s2[l-1] + (((BASE << ((l - 1) % 2)) > SHIFT) ? (BASE << ((l - 1) % 2)) : SHIFT)) + BL + 2;
    end
    fill_image(1'b0);
    repeat (3) @(negedge clk);
    check_reset(0, oe1, st1, fs1, ck1, ad1, dat1, x1, y1);
    check_reset(1, oe2, st2, fs2, ck2, ad2, dat2, x2, y2);
    rst_n = 1'b1;
    run(700);
    #2 rst_n = 1'b0;
    #1;
    check_reset(0, oe1, st1, fs1, ck1, ad1, dat1, x1, y1);
    check_reset(1, oe2, st2, fs2, ck2, ad2, dat2, x2, y2);
    fill_image(1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(8750);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
